// File: rtl/nd_loop_counter.sv
// Nested-loop iteration counter: DIMS dimensions (dim 0 innermost), inclusive maxima,
// start/busy/done handshake with single-shot or continuous sweeps and per-level last flags.
module nd_loop_counter #(
  parameter int SIZE = 12,
  parameter int DIMS = 3
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 en,
  input  logic                 cont,
  input  logic [DIMS*SIZE-1:0] max_flat,
  output logic [DIMS*SIZE-1:0] count_flat,
  output logic [DIMS-1:0]      last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [DIMS*SIZE-1:0]  r_count;
  logic [DIMS*SIZE-1:0]  r_max;
  logic                  r_cont;
  logic                  r_done;

  logic [DIMS*SIZE-1:0]  w_count_nxt;
  logic [DIMS-1:0]       w_prefix;
  logic                  w_carry;
  logic                  w_atmax;
  logic                  w_final;

  // w_carry entering dim i means dims 0..i-1 are all at max, so dim i steps this beat.
  always_comb begin
    w_count_nxt = r_count;
    w_prefix    = '0;
    w_carry     = 1'b1;
    w_atmax     = 1'b0;
    for (int i = 0; i < DIMS; i++) begin
      w_atmax = (r_count[i*SIZE +: SIZE] == r_max[i*SIZE +: SIZE]);
      if (w_carry) begin
        w_count_nxt[i*SIZE +: SIZE] = w_atmax ? '0 : (r_count[i*SIZE +: SIZE] + ONE);
      end
      w_carry     = w_carry & w_atmax;
      w_prefix[i] = w_carry;
    end
  end

  assign w_final    = w_prefix[DIMS-1];
  assign last       = {DIMS{(r_state == RUN) & ~clr}} & w_prefix;
  assign count_flat = r_count;
  assign busy       = (r_state == RUN);
  assign done       = r_done;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_max   <= '0;
      r_cont  <= 1'b0;
      r_done  <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_max   <= max_flat;
            r_cont  <= cont;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            // The final beat wraps every dimension back to zero through w_count_nxt.
            r_count <= w_count_nxt;
            if (w_final) begin
              r_done <= 1'b1;
              if (!r_cont) r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
